// File: rtl/lvds_pkg.sv
// Shared types and lane mapping for the 7-lane 7:1 LVDS link controller.
package lvds_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RST_HOLD,
        ST_TRAIN,
        ST_RUN
    } link_state_t;

    localparam int LANES = 7;
    localparam int SLOTS = 7;

    // Slot 0 in the LSB, i.e. the first bit shifted out.
    localparam logic [SLOTS-1:0] CLK_PATTERN = 7'b1100011;

    typedef struct packed {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } pixel_t;

    localparam pixel_t BLANK_PIXEL = '{rgb: 24'h0, de: 1'b0, hs: 1'b0, vs: 1'b0};

    function automatic logic [LANES*SLOTS-1:0] map_lanes(input pixel_t p, input logic clk_en);
        logic [LANES-1:0][SLOTS-1:0] lane;
        logic [7:0] r, g, b;
        logic [LANES*SLOTS-1:0] w;
        r = p.rgb[23:16];
        g = p.rgb[15:8];
        b = p.rgb[7:0];
        lane[0] = {g[0], r[5:0]};
        lane[1] = {b[1:0], g[5:1]};
        lane[2] = {p.de, p.vs, p.hs, b[5:2]};
        lane[3] = {1'b0, b[7:6], g[7:6], r[7:6]};
        lane[4] = clk_en ? CLK_PATTERN : '0;
        lane[5] = '0;
        lane[6] = '0;
        // Serializer word is slot-major: din[k*LANES + L] is slot k of lane L.
        for (int k = 0; k < SLOTS; k++) begin
            for (int l = 0; l < LANES; l++) begin
                w[k*LANES + l] = lane[l][k];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lvds_lane_packer.sv
// Combinational packer: one pixel plus clock-lane enable into the 49-bit serializer word.
module lvds_lane_packer
    import lvds_pkg::*;
(
    input  logic [23:0]            rgb,
    input  logic                   de,
    input  logic                   hs,
    input  logic                   vs,
    input  logic                   clk_en,
    output logic [LANES*SLOTS-1:0] word
);

    pixel_t pix;

    always_comb begin
        pix.rgb = rgb;
        pix.de  = de;
        pix.hs  = hs;
        pix.vs  = vs;
    end

    assign word = map_lanes(pix, clk_en);

endmodule

// File: rtl/lvds_link_ctrl.sv
// LVDS link sequencer: serializer reset hold, clock-only training, then pixel packing.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_OFF      | link down, serializer in reset, din all zero
// ST_RST_HOLD | lock+enable seen, serializer still in reset, clock lane on
// ST_TRAIN    | serializer running, clock-only blank words
// ST_RUN      | pixels accepted and packed, link_up high
module lvds_link_ctrl
    import lvds_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int TRAIN_CYCLES = 1024
) (
    input  logic        pclk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        pll_lock,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_rgb,
    input  logic        pix_de,
    input  logic        pix_hs,
    input  logic        pix_vs,
    output logic        ser_reset,
    output logic [48:0] din,
    output logic        link_up,
    output logic [15:0] underflow_cnt
);

    localparam int CNT_MAX = (RST_CYCLES > TRAIN_CYCLES) ? RST_CYCLES : TRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAIN_LOAD = CNT_W'(TRAIN_CYCLES - 1);

    link_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic                   hs_hold;
    logic                   vs_hold;
    logic                   de_last;
    logic                   accept;
    logic                   link_ok;
    pixel_t                 pix_sel;
    logic [LANES*SLOTS-1:0] word_nxt;

    assign accept  = pix_valid & pix_ready;
    assign link_ok = enable & pll_lock;

    // Idle RUN cycles repeat the last syncs with DE low; hold regs are zero outside RUN.
    always_comb begin
        pix_sel    = BLANK_PIXEL;
        pix_sel.hs = hs_hold;
        pix_sel.vs = vs_hold;
        if (accept) begin
            pix_sel.rgb = pix_rgb;
            pix_sel.de  = pix_de;
            pix_sel.hs  = pix_hs;
            pix_sel.vs  = pix_vs;
        end
    end

    lvds_lane_packer u_packer (
        .rgb    (pix_sel.rgb),
        .de     (pix_sel.de),
        .hs     (pix_sel.hs),
        .vs     (pix_sel.vs),
        .clk_en (1'b1),
        .word   (word_nxt)
    );

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_OFF;
            cnt       <= '0;
            hs_hold   <= 1'b0;
            vs_hold   <= 1'b0;
            de_last   <= 1'b0;
            ser_reset <= 1'b1;
            pix_ready <= 1'b0;
            link_up   <= 1'b0;
            din       <= '0;
        end else if (!link_ok) begin
            state     <= ST_OFF;
            cnt       <= '0;
            hs_hold   <= 1'b0;
            vs_hold   <= 1'b0;
            de_last   <= 1'b0;
            ser_reset <= 1'b1;
            pix_ready <= 1'b0;
            link_up   <= 1'b0;
            din       <= '0;
        end else begin
            din <= word_nxt;
            case (state)
                ST_OFF: begin
                    state     <= ST_RST_HOLD;
                    cnt       <= RST_LOAD;
                    ser_reset <= 1'b1;
                end
                ST_RST_HOLD: begin
                    if (cnt == '0) begin
                        state     <= ST_TRAIN;
                        cnt       <= TRAIN_LOAD;
                        ser_reset <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_TRAIN: begin
                    if (cnt == '0) begin
                        state     <= ST_RUN;
                        pix_ready <= 1'b1;
                        link_up   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        hs_hold <= pix_hs;
                        vs_hold <= pix_vs;
                        de_last <= pix_de;
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            underflow_cnt <= '0;
        end else if (state == ST_RUN && !pix_valid && de_last && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lvds_link_ctrl.sv
// Scoreboard bench for lvds_link_ctrl with RST_CYCLES=4, TRAIN_CYCLES=8.
module tb_lvds_link_ctrl;

    localparam logic [48:0] BLANK_CLK = 49'h0408000000810;
    localparam logic [48:0] PIX_A5    = 49'h050F810A04C9D;

    logic        pclk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        pll_lock;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_rgb;
    logic        pix_de;
    logic        pix_hs;
    logic        pix_vs;
    logic        ser_reset;
    logic [48:0] din;
    logic        link_up;
    logic [15:0] underflow_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [48:0] exp_q[$];
    logic        m_hs, m_vs, m_de;
    logic [15:0] m_uf;

    always #5 pclk = ~pclk;

    lvds_link_ctrl #(.RST_CYCLES(4), .TRAIN_CYCLES(8)) dut (
        .pclk          (pclk),
        .resetn        (resetn),
        .enable        (enable),
        .pll_lock      (pll_lock),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_rgb       (pix_rgb),
        .pix_de        (pix_de),
        .pix_hs        (pix_hs),
        .pix_vs        (pix_vs),
        .ser_reset     (ser_reset),
        .din           (din),
        .link_up       (link_up),
        .underflow_cnt (underflow_cnt)
    );

    // Reference word built slot by slot from the lane table.
    function automatic logic [48:0] tb_word(input logic [23:0] rgb, input logic de,
                                            input logic hs, input logic vs, input logic clk);
        logic [6:0]  l [7];
        logic [7:0]  r, g, b;
        logic [48:0] w;
        r = rgb[23:16];
        g = rgb[15:8];
        b = rgb[7:0];
        for (int i = 0; i < 7; i++) l[i] = 7'd0;
        for (int s = 0; s < 6; s++) l[0][s] = r[s];
        l[0][6] = g[0];
        for (int s = 0; s < 5; s++) l[1][s] = g[s+1];
        l[1][5] = b[0];
        l[1][6] = b[1];
        for (int s = 0; s < 4; s++) l[2][s] = b[s+2];
        l[2][4] = hs;
        l[2][5] = vs;
        l[2][6] = de;
        l[3][0] = r[6]; l[3][1] = r[7]; l[3][2] = g[6];
        l[3][3] = g[7]; l[3][4] = b[6]; l[3][5] = b[7];
        l[4][0] = clk; l[4][1] = clk; l[4][5] = clk; l[4][6] = clk;
        for (int k = 0; k < 7; k++)
            for (int ln = 0; ln < 7; ln++)
                w[k*7 + ln] = l[ln][k];
        return w;
    endfunction

    task automatic drive_cycle(input logic v, input logic [23:0] rgb,
                               input logic de, input logic hs, input logic vs);
        logic [48:0] exp_w;
        pix_valid = v;
        pix_rgb   = rgb;
        pix_de    = de;
        pix_hs    = hs;
        pix_vs    = vs;
        if (v) begin
            exp_q.push_back(tb_word(rgb, de, hs, vs, 1'b1));
            m_hs = hs; m_vs = vs; m_de = de;
        end else begin
            exp_q.push_back(tb_word(24'h0, 1'b0, m_hs, m_vs, 1'b1));
            if (m_de && m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
        end
        n_tests++;
        if (pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL run_ready: got %b want 1", pix_ready);
        end
        @(posedge pclk); #1;
        exp_w = exp_q.pop_front();
        n_tests++;
        if (din !== exp_w) begin
            n_fail++;
            $display("FAIL run_din: got %h want %h", din, exp_w);
        end
        n_tests++;
        if (underflow_cnt !== m_uf) begin
            n_fail++;
            $display("FAIL run_underflow: got %0d want %0d", underflow_cnt, m_uf);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; pll_lock = 1'b0; pix_valid = 1'b0;
        pix_rgb = '0; pix_de = 1'b0; pix_hs = 1'b0; pix_vs = 1'b0;
        m_hs = 1'b0; m_vs = 1'b0; m_de = 1'b0; m_uf = '0;
        repeat (3) @(posedge pclk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        n_tests += 5;
        if (ser_reset !== 1'b1)   begin n_fail++; $display("FAIL reset_ser_reset: got %b want 1", ser_reset); end
        if (din !== '0)           begin n_fail++; $display("FAIL reset_din: got %h want 0", din); end
        if (pix_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
        if (link_up !== 1'b0)     begin n_fail++; $display("FAIL reset_link_up: got %b want 0", link_up); end
        if (underflow_cnt !== '0) begin n_fail++; $display("FAIL reset_underflow: got %0d want 0", underflow_cnt); end
    endtask

    task automatic test_bringup();
        logic exp_sr, exp_up;
        enable = 1'b1; pll_lock = 1'b1; pix_valid = 1'b0;
        m_hs = 1'b0; m_vs = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            @(posedge pclk); #1;
            exp_sr = (c <= 4);
            exp_up = (c == 13);
            n_tests += 4;
            if (ser_reset !== exp_sr) begin n_fail++; $display("FAIL bringup_ser_reset c%0d: got %b want %b", c, ser_reset, exp_sr); end
            if (pix_ready !== exp_up) begin n_fail++; $display("FAIL bringup_pix_ready c%0d: got %b want %b", c, pix_ready, exp_up); end
            if (link_up !== exp_up)   begin n_fail++; $display("FAIL bringup_link_up c%0d: got %b want %b", c, link_up, exp_up); end
            if (din !== BLANK_CLK)    begin n_fail++; $display("FAIL bringup_din c%0d: got %h want %h", c, din, BLANK_CLK); end
        end
    endtask

    task automatic test_packing();
        logic [6:0] clk_lane;
        drive_cycle(1'b1, 24'hFF00A5, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) clk_lane[k] = din[k*7 + 4];
        n_tests += 3;
        if (din !== PIX_A5) begin n_fail++; $display("FAIL pack_const: got %h want %h", din, PIX_A5); end
        if (clk_lane !== 7'b1100011) begin n_fail++; $display("FAIL pack_clk_lane: got %b want 1100011", clk_lane); end
        for (int k = 0; k < 7; k++) begin
            if (din[k*7 + 5] !== 1'b0 || din[k*7 + 6] !== 1'b0) begin
                n_fail++;
                $display("FAIL pack_lane56 slot%0d: got %b%b want 00", k, din[k*7 + 6], din[k*7 + 5]);
                break;
            end
        end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 24'h123456, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (underflow_cnt !== 16'd3) begin n_fail++; $display("FAIL starve_count3: got %0d want 3", underflow_cnt); end
        drive_cycle(1'b1, 24'h0F0F0F, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (underflow_cnt !== 16'd3) begin n_fail++; $display("FAIL starve_hold3: got %0d want 3", underflow_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            drive_cycle(($urandom_range(0, 3) != 0), 24'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_saturation();
        drive_cycle(1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b0);
        pix_valid = 1'b0;
        repeat (70000) @(posedge pclk);
        #1;
        m_uf = 16'hFFFF;
        n_tests++;
        if (underflow_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL saturate: got %h want ffff", underflow_cnt); end
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lock_loss();
        drive_cycle(1'b1, 24'h55AA33, 1'b1, 1'b1, 1'b1);
        pix_valid = 1'b1; pix_rgb = 24'h777777; pix_de = 1'b1; pix_hs = 1'b1; pix_vs = 1'b0;
        pll_lock = 1'b0;
        n_tests++;
        if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL lock_loss_ready_pre: got %b want 1", pix_ready); end
        @(posedge pclk); #1;
        m_hs = 1'b0; m_vs = 1'b0; m_de = 1'b0;
        n_tests += 5;
        if (din !== '0)          begin n_fail++; $display("FAIL lock_loss_din: got %h want 0", din); end
        if (ser_reset !== 1'b1)  begin n_fail++; $display("FAIL lock_loss_ser_reset: got %b want 1", ser_reset); end
        if (pix_ready !== 1'b0)  begin n_fail++; $display("FAIL lock_loss_ready: got %b want 0", pix_ready); end
        if (link_up !== 1'b0)    begin n_fail++; $display("FAIL lock_loss_link_up: got %b want 0", link_up); end
        if (underflow_cnt !== m_uf) begin n_fail++; $display("FAIL lock_loss_underflow: got %0d want %0d", underflow_cnt, m_uf); end
        test_bringup();
        drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 24'h010203, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        pix_valid = 1'b1; pix_rgb = 24'hC0FFEE; pix_de = 1'b1; pix_hs = 1'b1; pix_vs = 1'b1;
        @(posedge pclk); #3;
        resetn = 1'b0;
        #1;
        n_tests += 5;
        if (ser_reset !== 1'b1)   begin n_fail++; $display("FAIL areset_ser_reset: got %b want 1", ser_reset); end
        if (din !== '0)           begin n_fail++; $display("FAIL areset_din: got %h want 0", din); end
        if (pix_ready !== 1'b0)   begin n_fail++; $display("FAIL areset_ready: got %b want 0", pix_ready); end
        if (link_up !== 1'b0)     begin n_fail++; $display("FAIL areset_link_up: got %b want 0", link_up); end
        if (underflow_cnt !== '0) begin n_fail++; $display("FAIL areset_underflow: got %0d want 0", underflow_cnt); end
        @(negedge pclk);
        resetn = 1'b1;
        @(posedge pclk); #1;
        n_tests += 3;
        if (din !== BLANK_CLK)  begin n_fail++; $display("FAIL areset_release_din: got %h want %h", din, BLANK_CLK); end
        if (ser_reset !== 1'b1) begin n_fail++; $display("FAIL areset_release_ser_reset: got %b want 1", ser_reset); end
        if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL areset_release_ready: got %b want 0", pix_ready); end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bringup();
        test_packing();
        test_starvation();
        test_back_to_back();
        test_saturation();
        test_lock_loss();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
